// File: rtl/i2s_pkg.sv
// Shared constants and FSM encoding for the I2S clock generator.
package i2s_pkg;

  localparam int unsigned SLOT_16 = 16;
  localparam int unsigned SLOT_24 = 24;
  localparam int unsigned SLOT_32 = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Half-period-minus-one for 64-BCLK frames from 50 MHz, nearest integer divide.
  localparam int unsigned HALF_48K  = 7;
  localparam int unsigned HALF_44K1 = 8;

endpackage

// File: rtl/i2s_half_div.sv
// Programmable half-period counter; tick_c marks the cycle where BCLK toggles.
module i2s_half_div #(
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEFAULT_HALF = 7
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] half_i,
  output logic             tick_c
);

  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] hc_q, hc_d;

  assign tick_c = run_i && (hc_q == half_q);

  // A load always restarts the count so the new divide starts from a clean phase.
  always_comb begin
    half_d = half_q;
    hc_d   = hc_q;
    if (load_i) half_d = half_i;
    if (!run_i || load_i || tick_c) hc_d = '0;
    else                            hc_d = hc_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= DIV_W'(DEFAULT_HALF);
      hc_q   <= '0;
    end else begin
      half_q <= half_d;
      hc_q   <= hc_d;
    end
  end

endmodule

// File: rtl/i2s_clk_gen.sv
// I2S BCLK/LRCLK generator with clk_in-domain edge strobes and runtime divide.
// Define I2S_LR_DELAY_EN for Philips-style LRCLK (one BCLK ahead of the slot MSB).
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEFAULT_HALF = 7,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned BIT_W        = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_half,
  input  logic             cfg_load,
  output logic             cfg_ack,
  output logic             bclk,
  output logic             lrclk,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             frame_start,
  output logic [BIT_W-1:0] bit_idx,
  output logic             running
);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pending_q, pending_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;
  logic             ack_q;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [BIT_W-1:0] bit_nxt_c;
  logic [DIV_W-1:0] load_val_c;
  logic             apply_c;
  logic             run_c;
  logic             tick_c;

  function automatic logic lr_of(input logic [BIT_W-1:0] idx);
`ifdef I2S_LR_DELAY_EN
    return (idx >= BIT_W'(SLOT_BITS - 1)) && (idx <= BIT_W'(2 * SLOT_BITS - 2));
`else
    return idx >= BIT_W'(SLOT_BITS);
`endif
  endfunction

  assign run_c = (state_q == ST_RUN) && enable;

  i2s_half_div #(
    .DIV_W       (DIV_W),
    .DEFAULT_HALF(DEFAULT_HALF)
  ) u_half_div (
    .clk_i (clk_in),
    .rst_n (rst_n),
    .run_i (run_c),
    .load_i(apply_c),
    .half_i(load_val_c),
    .tick_c(tick_c)
  );

  always_comb begin
    state_d   = state_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    bit_d     = bit_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    fs_d      = 1'b0;
    apply_c   = 1'b0;
    bit_nxt_c = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);

    if (state_q == ST_IDLE) begin
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      bit_d   = '0;
      apply_c = cfg_load || pending_q;
      if (enable) state_d = ST_RUN;
    end else if (!enable) begin
      state_d = ST_IDLE;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      bit_d   = '0;
    end else if (tick_c) begin
      bclk_d = !bclk_q;
      if (bclk_q) begin
        fall_d  = 1'b1;
        bit_d   = bit_nxt_c;
        lrclk_d = lr_of(bit_nxt_c);
        if (bit_nxt_c == '0) begin
          fs_d    = 1'b1;
          apply_c = pending_q;
        end
      end else begin
        rise_d = 1'b1;
      end
    end

    // Idle loads bypass the pending register; running loads wait for a frame boundary.
    load_val_c = ((state_q == ST_IDLE) && cfg_load) ? cfg_half : pend_q;
    pend_d     = pend_q;
    pending_d  = pending_q;
    if (apply_c) pending_d = 1'b0;
    if (cfg_load && (state_q == ST_RUN)) begin
      pend_d    = cfg_half;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      pending_q <= 1'b0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      fs_q      <= 1'b0;
      ack_q     <= 1'b0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      fs_q      <= fs_d;
      ack_q     <= apply_c;
      bit_q     <= bit_d;
    end
  end

  assign cfg_ack     = ack_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign frame_start = fs_q;
  assign bit_idx     = bit_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Directed bench for i2s_clk_gen (default build or with I2S_LR_DELAY_EN defined).
module tb_i2s_clk_gen;

  localparam int unsigned DIV_W     = 8;
  localparam int unsigned SLOT_BITS = 32;
  localparam int unsigned BIT_W     = 6;
`ifdef I2S_LR_DELAY_EN
  localparam int LR_RISE_IDX = 31;
  localparam int LR_FALL_IDX = 63;
`else
  localparam int LR_RISE_IDX = 32;
  localparam int LR_FALL_IDX = 0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_load;
  logic             cfg_ack;
  logic             bclk;
  logic             lrclk;
  logic             bclk_rise;
  logic             bclk_fall;
  logic             frame_start;
  logic [BIT_W-1:0] bit_idx;
  logic             running;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  i2s_clk_gen #(
    .DIV_W       (DIV_W),
    .DEFAULT_HALF(7),
    .SLOT_BITS   (SLOT_BITS)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_half   (cfg_half),
    .cfg_load   (cfg_load),
    .cfg_ack    (cfg_ack),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .bclk_rise  (bclk_rise),
    .bclk_fall  (bclk_fall),
    .frame_start(frame_start),
    .bit_idx    (bit_idx),
    .running    (running)
  );

  function automatic logic exp_lr(input int idx);
`ifdef I2S_LR_DELAY_EN
    return (idx >= 31) && (idx <= 62);
`else
    return idx >= 32;
`endif
  endfunction

  function automatic logic [12:0] outs();
    return {cfg_ack, bclk, lrclk, bclk_rise, bclk_fall, frame_start, running, bit_idx};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    cfg_load = 1'b0;
    cfg_half = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    cfg_load = 1'b0;
    cfg_half = '0;
    #12;
    n_checks++;
    if (outs() !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero", outs());
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (outs() !== 13'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected all zero", outs());
    end
  endtask

  task automatic test_basic();
    int first_rise = -1, second_rise = -1, first_fall = -1, fs_at = -1;
    int lr_bad = 0, strobe_bad = 0, lr_up_idx = -1, lr_dn_idx = -1, bit_1024 = -1;
    logic prev_b = 1'b0, prev_lr = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 1040; c++) begin
      step();
      if (c == 1) begin
        n_checks++;
        if ({running, bclk} !== 2'b10) begin
          n_fail++;
          $display("FAIL basic_enter_run: running,bclk=%b expected 10", {running, bclk});
        end
      end
      if (lrclk !== exp_lr(int'(bit_idx))) lr_bad++;
      if (bclk_rise !== (bclk && !prev_b)) strobe_bad++;
      if (bclk_fall !== (!bclk && prev_b)) strobe_bad++;
      if (bclk_rise && first_rise < 0) first_rise = c;
      else if (bclk_rise && second_rise < 0) second_rise = c;
      if (bclk_fall && first_fall < 0) first_fall = c;
      if (frame_start && fs_at < 0) fs_at = c;
      if (lrclk && !prev_lr && lr_up_idx < 0) lr_up_idx = int'(bit_idx);
      if (!lrclk && prev_lr && lr_dn_idx < 0) lr_dn_idx = int'(bit_idx);
      if (c == 1024) bit_1024 = int'(bit_idx);
      prev_b  = bclk;
      prev_lr = lrclk;
    end
    n_checks++;
    if (first_rise != 9) begin n_fail++; $display("FAIL basic_first_rise: got %0d expected 9", first_rise); end
    n_checks++;
    if (first_fall != 17) begin n_fail++; $display("FAIL basic_first_fall: got %0d expected 17", first_fall); end
    n_checks++;
    if (second_rise != 25) begin n_fail++; $display("FAIL basic_period: second rise %0d expected 25", second_rise); end
    n_checks++;
    if (fs_at != 1025) begin n_fail++; $display("FAIL basic_frame_start: got %0d expected 1025", fs_at); end
    n_checks++;
    if (bit_1024 != 63) begin n_fail++; $display("FAIL basic_last_bit: got %0d expected 63", bit_1024); end
    n_checks++;
    if (lr_up_idx != LR_RISE_IDX) begin n_fail++; $display("FAIL lr_rise_idx: got %0d expected %0d", lr_up_idx, LR_RISE_IDX); end
    n_checks++;
    if (lr_dn_idx != LR_FALL_IDX) begin n_fail++; $display("FAIL lr_fall_idx: got %0d expected %0d", lr_dn_idx, LR_FALL_IDX); end
    n_checks++;
    if (lr_bad != 0) begin n_fail++; $display("FAIL lr_vs_bit_idx: %0d bad cycles expected 0", lr_bad); end
    n_checks++;
    if (strobe_bad != 0) begin n_fail++; $display("FAIL strobe_vs_bclk: %0d bad cycles expected 0", strobe_bad); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_half0();
    int alt_bad = 0, bit_bad = 0;
    logic exp_b;
    do_reset();
    cfg_half = 8'd0;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n_checks++;
    if ({cfg_ack, running} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_cfg_ack: ack,running=%b expected 10", {cfg_ack, running});
    end
    step();
    n_checks++;
    if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL idle_cfg_ack_single: got %b expected 0", cfg_ack); end
    enable = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_b = logic'(k % 2);
      if ({bclk, bclk_rise, bclk_fall} !== {exp_b, exp_b, !exp_b}) alt_bad++;
      if (int'(bit_idx) != k / 2) bit_bad++;
    end
    n_checks++;
    if (alt_bad != 0) begin n_fail++; $display("FAIL div2_alternate: %0d bad cycles expected 0", alt_bad); end
    n_checks++;
    if (bit_bad != 0) begin n_fail++; $display("FAIL div2_bit_idx: %0d bad cycles expected 0", bit_bad); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_cfg_midframe();
    int fs_q[$];
    int ack_q[$];
    int rise_q[$];
    bit l1 = 1'b0, l2 = 1'b0;
    int hold_at = -1, int_bad = 0, prev_r = -1;
    int r1 = -1, r2 = -1, r3 = -1, r4 = -1, fs1, fs2;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 1600; c++) begin
      step();
      if (cfg_ack) ack_q.push_back(c);
      if (frame_start) fs_q.push_back(c);
      if (bclk_rise) rise_q.push_back(c);
      cfg_load = 1'b0;
      if (!l1 && bit_idx == 6'd10) begin cfg_half = 8'd4; cfg_load = 1'b1; l1 = 1'b1; end
      else if (!l2 && bit_idx == 6'd20) begin cfg_half = 8'd3; cfg_load = 1'b1; l2 = 1'b1; end
      if (fs_q.size() == 0 && bit_idx == 6'd63 && bclk_rise) hold_at = c + 7;
      if (c == hold_at) begin cfg_half = 8'd5; cfg_load = 1'b1; end
    end
    cfg_load = 1'b0;
    n_checks++;
    if (fs_q.size() < 2) begin
      n_fail++;
      $display("FAIL cfg_frames_seen: got %0d frame_starts expected 2", fs_q.size());
    end else begin
      fs1 = fs_q[0];
      fs2 = fs_q[1];
      foreach (rise_q[i]) begin
        if (rise_q[i] < fs1) begin
          if (prev_r >= 0 && rise_q[i] - prev_r != 16) int_bad++;
          prev_r = rise_q[i];
        end else if (rise_q[i] < fs2) begin
          if (r1 < 0) r1 = rise_q[i]; else if (r2 < 0) r2 = rise_q[i];
        end else begin
          if (r3 < 0) r3 = rise_q[i]; else if (r4 < 0) r4 = rise_q[i];
        end
      end
      n_checks++;
      if (fs1 != 1025) begin n_fail++; $display("FAIL cfg_fs1: got %0d expected 1025", fs1); end
      n_checks++;
      if (int_bad != 0) begin n_fail++; $display("FAIL cfg_period_before: %0d bad intervals expected 0", int_bad); end
      n_checks++;
      if (ack_q.size() != 2) begin n_fail++; $display("FAIL cfg_ack_count: got %0d expected 2", ack_q.size()); end
      n_checks++;
      if (ack_q.size() < 1 || ack_q[0] != fs1) begin
        n_fail++;
        $display("FAIL cfg_ack_at_fs1: got %0d expected %0d", (ack_q.size() > 0) ? ack_q[0] : -1, fs1);
      end
      n_checks++;
      if (ack_q.size() < 2 || ack_q[1] != fs2) begin
        n_fail++;
        $display("FAIL cfg_ack_held: got %0d expected %0d", (ack_q.size() > 1) ? ack_q[1] : -1, fs2);
      end
      n_checks++;
      if (fs2 != fs1 + 512) begin n_fail++; $display("FAIL cfg_frame_len_half3: got %0d expected %0d", fs2, fs1 + 512); end
      n_checks++;
      if (r1 != fs1 + 4 || r2 != fs1 + 12) begin
        n_fail++;
        $display("FAIL cfg_half3_rises: got %0d,%0d expected %0d,%0d", r1, r2, fs1 + 4, fs1 + 12);
      end
      n_checks++;
      if (r3 != fs2 + 6 || r4 != fs2 + 18) begin
        n_fail++;
        $display("FAIL cfg_half5_rises: got %0d,%0d expected %0d,%0d", r3, r4, fs2 + 6, fs2 + 18);
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_enable_drop();
    bit found = 1'b0;
    int first_rise = -1;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 2000 && !found; k++) begin
      step();
      if (bit_idx == 6'd40) found = 1'b1;
    end
    n_checks++;
    if (!found || lrclk !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_reach_bit40: found=%0d lrclk=%b expected 1,1", found, lrclk);
    end
    enable = 1'b0;
    step();
    n_checks++;
    if (outs() !== 13'd0) begin n_fail++; $display("FAIL drop_idle_now: got %b expected all zero", outs()); end
    step();
    n_checks++;
    if (outs() !== 13'd0) begin n_fail++; $display("FAIL drop_idle_quiet: got %b expected all zero", outs()); end
    enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        n_checks++;
        if ({running, bit_idx} !== {1'b1, 6'd0}) begin
          n_fail++;
          $display("FAIL reenable_start: running=%b bit_idx=%0d expected 1,0", running, bit_idx);
        end
      end
      if (bclk_rise && first_rise < 0) first_rise = c;
    end
    n_checks++;
    if (first_rise != 9) begin n_fail++; $display("FAIL reenable_first_rise: got %0d expected 9", first_rise); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    int ack_seen = 0, first_rise = -1;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (bit_idx == 6'd5) found = 1'b1;
    end
    cfg_half = 8'd3;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
    step();
    n_checks++;
    if (!found || running !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_precondition: found=%0d running=%b expected 1,1", found, running);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 13'd0) begin n_fail++; $display("FAIL arst_immediate: got %b expected all zero", outs()); end
    enable = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (cfg_ack) ack_seen++;
    end
    n_checks++;
    if (ack_seen != 0) begin n_fail++; $display("FAIL arst_no_ack: got %0d acks expected 0", ack_seen); end
    enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bclk_rise && first_rise < 0) first_rise = c;
    end
    n_checks++;
    if (first_rise != 9) begin n_fail++; $display("FAIL arst_pending_dropped: first rise %0d expected 9", first_rise); end
    enable = 1'b0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_half0();
    test_cfg_midframe();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
